// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate format selector, instruction field
// positions and the encoded-beat record carried through the encoder pipeline.
package cpu_pkg;

    localparam int INST_W = 32;

    // Immediate formats, numbered identically in the decoder.
    typedef enum logic [1:0] {
        IMM_S_TYPE = 2'd0,
        IMM_SHIFT  = 2'd1,
        IMM_I_TYPE = 2'd2,
        IMM_U_TYPE = 2'd3
    } imm_type_e;

    localparam int S_HI_MSB   = 31;
    localparam int S_HI_LSB   = 25;
    localparam int S_LO_MSB   = 11;
    localparam int S_LO_LSB   = 7;
    localparam int SHAMT_MSB  = 25;
    localparam int SHAMT_LSB  = 20;
    localparam int I_MSB      = 31;
    localparam int I_LSB      = 20;
    localparam int U_MSB      = 31;
    localparam int U_LSB      = 12;
    localparam int U_IMM_BITS = U_MSB - U_LSB + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              err;
    } enc_beat_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Streaming interface of the immediate encoder: input template/immediate beats
// and output encoded instructions.
interface imm_encoder_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 4
);
    localparam int TYPE_W = $clog2(IMM_TYPE_NUM);

    // Valid/ready: a beat moves on the rising clock edge where valid && ready
    // are both high; once valid is raised the producer holds payload stable
    // until that edge, and ready never depends combinationally on valid.
    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_inst;
    logic [TYPE_W-1:0]     in_imm_type;
    logic [DATA_WIDTH-1:0] in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_inst;
    logic                  out_err;

    modport slave (
        input  in_valid, in_inst, in_imm_type, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

    modport master (
        output in_valid, in_inst, in_imm_type, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

endinterface

// File: rtl/imm_pack.sv
// Combinational immediate packer: inserts the immediate into the selected
// format's bit-fields of the template and flags values the format cannot hold.
module imm_pack
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic [INST_WIDTH-1:0] inst,
    input  imm_type_e             imm_type,
    input  logic [DATA_WIDTH-1:0] imm,
    output enc_beat_t             beat
);

    logic sext12_ok;
    logic shamt_ok;
    logic upper_ok;

    // 12-bit signed fields hold the value only if bits above 11 replicate bit 11.
    assign sext12_ok = (imm[DATA_WIDTH-1:11] == {(DATA_WIDTH-11){imm[11]}});
    assign shamt_ok  = (imm[DATA_WIDTH-1:6] == '0);
    assign upper_ok  = (imm[DATA_WIDTH-U_IMM_BITS-1:0] == '0);

    always_comb begin
        beat.inst = inst;
        beat.err  = 1'b0;
        case (imm_type)
            IMM_S_TYPE: begin
                beat.inst[S_HI_MSB:S_HI_LSB] = imm[11:5];
                beat.inst[S_LO_MSB:S_LO_LSB] = imm[4:0];
                beat.err                     = ~sext12_ok;
            end
            IMM_SHIFT: begin
                beat.inst[SHAMT_MSB:SHAMT_LSB] = imm[5:0];
                beat.err                       = ~shamt_ok;
            end
            IMM_I_TYPE: begin
                beat.inst[I_MSB:I_LSB] = imm[11:0];
                beat.err               = ~sext12_ok;
            end
            IMM_U_TYPE: begin
                beat.inst[U_MSB:U_LSB] = imm[DATA_WIDTH-1:DATA_WIDTH-U_IMM_BITS];
                beat.err               = ~upper_ok;
            end
            default: begin
                beat.err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder stream stage: packs immediates into instruction templates,
// with a registered output, one-entry skid buffer and saturating error counter.
module imm_encoder
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int INST_WIDTH    = 32,
    parameter int IMM_TYPE_NUM  = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    imm_encoder_if.slave             bus,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    enc_beat_t enc_beat;
    enc_beat_t out_q;
    enc_beat_t skid_q;
    logic      out_valid_q;
    logic      skid_valid_q;
    logic      in_fire;
    logic      out_fire;
    logic      out_free;

    imm_pack #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_pack (
        .inst     (bus.in_inst),
        .imm_type (imm_type_e'(bus.in_imm_type)),
        .imm      (bus.in_imm),
        .beat     (enc_beat)
    );

    // A beat offered in the flush cycle is dropped even though in_ready is high.
    assign in_fire  = bus.in_valid & ~skid_valid_q & ~flush;
    assign out_fire = out_valid_q & bus.out_ready;
    assign out_free = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            err_count    <= '0;
        end else begin
            if (out_fire && out_q.err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (out_free) begin
                // Skid has priority; in_ready is low while it is occupied.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (in_fire) begin
                    out_q       <= enc_beat;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q       <= enc_beat;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_q.inst;
    assign bus.out_err   = out_q.err;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: format vectors, back-pressure, flush,
// randomized traffic against a reference encoder, counter saturation and reset.
module tb_imm_encoder;
    import cpu_pkg::*;

    localparam int DW = 64;
    localparam int IW = 32;
    localparam int TN = 4;
    localparam int CW = 16;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  t;
        logic [63:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] err_count;
    logic [CW-1:0] exp_err_cnt;
    logic [32:0]   exp_q[$];
    logic [32:0]   mon_e;
    int            vectors = 0;
    int            miscompares = 0;
    bit            done;
    vec_t          tbl[14];

    imm_encoder_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .IMM_TYPE_NUM(TN)) bus ();

    imm_encoder #(
        .DATA_WIDTH    (DW),
        .INST_WIDTH    (IW),
        .IMM_TYPE_NUM  (TN),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .err_count (err_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before 5 ms");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    // Reference encoder from the format rules: signed range checks and masks.
    function automatic logic [32:0] ref_encode(logic [31:0] inst, logic [1:0] t, logic [63:0] imm);
        longint      s;
        logic        ok;
        logic [63:0] r;
        s = longint'(imm);
        r = {32'b0, inst};
        case (t)
            2'd0: begin
                ok = (s >= -2048) && (s <= 2047);
                r  = (r & ~64'hFE000F80) | (((imm >> 5) & 64'h7F) << 25) | ((imm & 64'h1F) << 7);
            end
            2'd1: begin
                ok = (imm < 64);
                r  = (r & ~64'h03F00000) | ((imm & 64'h3F) << 20);
            end
            2'd2: begin
                ok = (s >= -2048) && (s <= 2047);
                r  = (r & 64'h000FFFFF) | ((imm & 64'hFFF) << 20);
            end
            default: begin
                ok = ((imm & ((64'd1 << 44) - 1)) == 0);
                r  = (r & 64'hFFF) | ((imm >> 44) << 12);
            end
        endcase
        return {~ok, r[31:0]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send(logic [31:0] inst, logic [1:0] t, logic [63:0] imm, logic [32:0] exp);
        bus.in_valid    = 1'b1;
        bus.in_inst     = inst;
        bus.in_imm_type = t;
        bus.in_imm      = imm;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                exp_q.push_back(exp);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 1000 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // scoreboard: compare each output transfer against the expected queue
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got %h expected no beat", bus.out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_beat", {31'b0, bus.out_err, bus.out_inst}, {31'b0, mon_e});
                if (mon_e[32] && exp_err_cnt != '1) exp_err_cnt = exp_err_cnt + 1'b1;
            end
        end
        if (rst || flush) exp_q.delete();
    end

    initial begin
        logic [31:0] r_inst;
        logic [1:0]  r_t;
        logic [63:0] r_imm;
        int          v;

        tbl[0]  = '{32'h00000013, 2'd2, 64'hFFFFFFFFFFFFF800, 32'h80000013, 1'b0};
        tbl[1]  = '{32'h00003023, 2'd0, 64'd12,               32'h00003623, 1'b0};
        tbl[2]  = '{32'h00003023, 2'd0, 64'd2048,             32'h80003023, 1'b1};
        tbl[3]  = '{32'h00001013, 2'd1, 64'd63,               32'h03F01013, 1'b0};
        tbl[4]  = '{32'h00001013, 2'd1, 64'd64,               32'h00001013, 1'b1};
        tbl[5]  = '{32'h00000037, 2'd3, 64'h1234500000000000, 32'h12345037, 1'b0};
        tbl[6]  = '{32'h00000037, 2'd3, 64'h1234500000000001, 32'h12345037, 1'b1};
        tbl[7]  = '{32'h00000013, 2'd2, 64'd2047,             32'h7FF00013, 1'b0};
        tbl[8]  = '{32'h00000013, 2'd2, 64'd2048,             32'h80000013, 1'b1};
        tbl[9]  = '{32'h00000000, 2'd0, 64'hFFFFFFFFFFFFFFFF, 32'hFE000F80, 1'b0};
        tbl[10] = '{32'hFFFFFFFF, 2'd1, 64'd0,                32'hFC0FFFFF, 1'b0};
        tbl[11] = '{32'hFFFFFFFF, 2'd3, 64'd0,                32'h00000FFF, 1'b0};
        tbl[12] = '{32'h00000013, 2'd2, 64'hFFFFFFFFFFFFF7FF, 32'h7FF00013, 1'b1};
        tbl[13] = '{32'h00000000, 2'd0, 64'h0000000000010000, 32'h00000000, 1'b1};

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_imm_type = '0;
        bus.in_imm = '0;
        bus.out_ready = 1'b1;
        exp_err_cnt = '0;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // format vectors, one at a time
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].inst, tbl[i].t, tbl[i].imm, {tbl[i].exp_err, tbl[i].exp_inst});
            drain();
            check($sformatf("tbl%0d_err_count", i), err_count, exp_err_cnt);
            if (i == 2) check("first_err_count", err_count, 1);
        end
        check("tbl_err_total", err_count, 6);

        // back-pressure: skid fills on the second beat
        bus.out_ready = 1'b0;
        send(32'h00000013, 2'd2, 64'd5, {1'b0, 32'h00500013});
        check("bp_ready_after_1", bus.in_ready, 1);
        send(32'h00003023, 2'd0, 64'd2048, {1'b1, 32'h80003023});
        check("bp_ready_after_2", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_inst", bus.out_inst, 32'h00500013);
        check("bp_hold_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_rise", bus.in_ready, 1);
        send(32'h00001013, 2'd1, 64'd7, {1'b0, 32'h00701013});
        send(32'h00000037, 2'd3, 64'hABCDE00000000000, {1'b0, 32'hABCDE037});
        drain();
        check("bp_err_count", err_count, exp_err_cnt);

        // flush while an erroneous beat transfers and the skid is full
        bus.out_ready = 1'b0;
        send(32'h00001013, 2'd1, 64'd64, {1'b1, 32'h00001013});
        send(32'h00001013, 2'd1, 64'd7, {1'b0, 32'h00701013});
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_err_count", err_count, exp_err_cnt);

        // a beat offered during flush is discarded
        bus.in_valid = 1'b1;
        bus.in_inst = 32'h00000013;
        bus.in_imm_type = 2'd2;
        bus.in_imm = 64'd1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_drop_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("flush_drop_still_empty", bus.out_valid, 0);

        // randomized traffic with random back-pressure
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    r_inst = $urandom;
                    r_t = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: r_imm = {$urandom, $urandom};
                        1: begin
                            v = int'($urandom_range(0, 4200)) - 2100;
                            r_imm = 64'(longint'(v));
                        end
                        2: r_imm = 64'($urandom_range(0, 70));
                        default: r_imm = {20'($urandom), 43'b0, 1'($urandom_range(0, 3) == 0)};
                    endcase
                    send(r_inst, r_t, r_imm, ref_encode(r_inst, r_t, r_imm));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check("rand_err_count", err_count, exp_err_cnt);

        // saturation: 2^16+3 erroneous beats at full rate
        for (int i = 0; i < 65539; i++) begin
            send(32'h00001013, 2'd1, 64'd64, {1'b1, 32'h00001013});
        end
        drain();
        check("sat_err_count", err_count, 16'hFFFF);
        check("sat_model_count", err_count, exp_err_cnt);

        // reset mid-operation with output and skid occupied
        bus.out_ready = 1'b0;
        send(32'h00000013, 2'd2, 64'd5, {1'b0, 32'h00500013});
        send(32'h00000013, 2'd2, 64'd6, {1'b0, 32'h00600013});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err_cnt = '0;
        check("rst_mid_err_count", err_count, 0);
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        send(32'h00001013, 2'd1, 64'd3, {1'b0, 32'h00301013});
        drain();
        check("post_rst_err_count", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate decoding: packs a DATA_WIDTH-bit immediate into the immediate bit-fields of a 32-bit instruction template.
- Each result carries a representability flag.
- Used by the debug/boot instruction injector and by the self-test sequencer to build instructions on the fly.
- Streaming block with valid/ready on both sides, a one-cycle registered output and a skid buffer for full throughput.

Parameters:
- DATA_WIDTH, 64, width of the immediate operand.
- INST_WIDTH, 32, instruction width.
- IMM_TYPE_NUM, 4, number of immediate formats; selector width is $clog2(IMM_TYPE_NUM).
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all buffered entries
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_inst  input  INST_WIDTH  template; non-immediate fields passed through
- in_imm_type  input  $clog2(IMM_TYPE_NUM)  format selector
- in_imm  input  DATA_WIDTH  immediate value
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_inst  output  INST_WIDTH  encoded instruction
- out_err  output  1  immediate not representable in the selected format
- err_count  output  ERR_CNT_WIDTH  saturating count of results delivered with out_err=1

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_inst=0, out_err=0, err_count=0, skid empty. in_ready=1 in the first cycle after reset.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - out_inst and out_err are held stable while out_valid&&!out_ready.
- Latency: an accepted beat appears on out_* the next cycle when the output register is empty or draining.
- Throughput: one beat per cycle sustained while out_ready=1.
- Skid buffer:
  - in_ready is registered, equal to !skid_valid.
  - If a beat is accepted while the output register is full and not draining, it goes to the skid register.
  - On the next output transfer, skid moves to the output register and in_ready rises the following cycle.
  - Ordering is strictly FIFO.
  - No beat is dropped or duplicated.
- Encoding (combinational, before the register; all template bits outside the listed field are copied unchanged):
  - 2'b00 S-type: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]. err unless imm[DATA_WIDTH-1:11] are all equal.
  - 2'b01 shift: inst[25:20]=imm[5:0]; inst[31:26] kept. err unless imm[DATA_WIDTH-1:6]==0.
  - 2'b10 I-type: inst[31:20]=imm[11:0]. err unless imm[DATA_WIDTH-1:11] are all equal.
  - 2'b11 U-type: inst[31:12]=imm[DATA_WIDTH-1:DATA_WIDTH-20]. err unless imm[DATA_WIDTH-21:0]==0.
  - On err, the truncated field is still encoded as above.
- Round-trip property: when out_err=0, decoding out_inst with the same type reproduces in_imm exactly.
- err_count increments by 1 on each output transfer with out_err=1 and saturates at all-ones (no wrap).
- flush:
  - Next cycle, out_valid=0, the skid is empty and in_ready=1.
  - A beat presented during the flush cycle is discarded even if in_ready=1.
  - err_count is unaffected.
  - Simultaneous flush and output transfer: the transfer completes and err_count counts it.
- Reset mid-operation: all buffered beats are discarded and err_count clears; same cycle behaviour as flush plus the counter clear.
- Simultaneous accept and drain with an empty skid: the new beat goes directly to the output register; the skid stays empty.

Decomposition:
- Shared package cpu_pkg:
  - imm_type_e enum: IMM_S_TYPE=0, IMM_SHIFT=1, IMM_I_TYPE=2, IMM_U_TYPE=3, shared with the decoder.
  - Field bit-position constants.
  - Struct enc_beat_t {inst, err}.
- Sub-module imm_pack: purely combinational encoding plus range check. The top level holds the output register, skid buffer and counter.

Test Plan:
- I-type, in_inst=32'h00000013, imm=64'hFFFFFFFFFFFFF800 -> next cycle out_inst=32'h80000013, out_err=0.
- S-type, in_inst=32'h00003023, imm=12 -> out_inst=32'h00003623, out_err=0. Repeat with imm=2048 -> out_err=1, err_count=1.
- Shift, in_inst=32'h00001013, imm=63 -> out_inst=32'h03F01013. Repeat with imm=64 -> out_err=1, field=0.
- U-type, in_inst=32'h00000037, imm=64'h12345_00000000000 -> out_inst=32'h12345037, err=0. Repeat with imm low bit set -> err=1.
- Back-pressure: 4 beats back-to-back with out_ready=0 -> in_ready falls after beat 2. Release out_ready -> all 4 emerge in order, none lost; flush mid-stream -> out_valid=0 next cycle.
- Saturation: preload via 2^16+3 erroneous beats -> err_count=16'hFFFF; assert rst -> err_count=0, out_valid=0 next cycle.
